// File: rtl/window_ctrl_pkg.sv
// Shared types and defaults for the parametrised window controller.
package window_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_e;

  localparam int unsigned DEF_X_BITWIDTH     = 10;
  localparam int unsigned DEF_Y_BITWIDTH     = 10;
  localparam int unsigned DEF_PIXEL_BITWIDTH = 8;
  localparam int unsigned DEF_SCREEN_W       = 640;
  localparam int unsigned DEF_SCREEN_H       = 480;
  localparam int unsigned DEF_BUFFER_W       = 16;
  localparam int unsigned DEF_BUFFER_H       = 16;

  // Width of a counter able to hold 0..buffer_h inclusive.
  function automatic int unsigned rows_w(input int unsigned buffer_h);
    return $clog2(buffer_h + 1);
  endfunction

endpackage

// File: rtl/window_ctrl_param_if.sv
// Camera-stream / window-buffer / mult_adder bundle seen by the window controller.
interface window_ctrl_param_if #(
  parameter int unsigned X_BITWIDTH     = window_ctrl_pkg::DEF_X_BITWIDTH,
  parameter int unsigned Y_BITWIDTH     = window_ctrl_pkg::DEF_Y_BITWIDTH,
  parameter int unsigned PIXEL_BITWIDTH = window_ctrl_pkg::DEF_PIXEL_BITWIDTH,
  parameter int unsigned BUFFER_H       = window_ctrl_pkg::DEF_BUFFER_H
) ();
  localparam int unsigned ROWS_W = window_ctrl_pkg::rows_w(BUFFER_H);

  logic [X_BITWIDTH-1:0]     buffer_x_pos;
  logic [Y_BITWIDTH-1:0]     buffer_y_pos;
  logic                      pixel_valid;
  logic [X_BITWIDTH-1:0]     screen_x;
  logic [Y_BITWIDTH-1:0]     screen_y;
  logic [PIXEL_BITWIDTH-1:0] pixel_in;
  logic                      rdy_ack;
  logic [PIXEL_BITWIDTH-1:0] pixel_out;
  logic                      shift_left;
  logic                      shift_up;
  logic                      buffer_rdy;
  logic                      overrun;
  logic                      pos_err;
  logic [ROWS_W-1:0]         rows_filled;

  modport master (
    output buffer_x_pos, buffer_y_pos, pixel_valid, screen_x, screen_y, pixel_in, rdy_ack,
    input  pixel_out, shift_left, shift_up, buffer_rdy, overrun, pos_err, rows_filled
  );

  modport slave (
    input  buffer_x_pos, buffer_y_pos, pixel_valid, screen_x, screen_y, pixel_in, rdy_ack,
    output pixel_out, shift_left, shift_up, buffer_rdy, overrun, pos_err, rows_filled
  );
endinterface

// File: rtl/window_bounds_cmp.sv
// Combinational window geometry: in-window, last column/row and out-of-screen flags.
module window_bounds_cmp #(
  parameter int unsigned X_BITWIDTH = window_ctrl_pkg::DEF_X_BITWIDTH,
  parameter int unsigned Y_BITWIDTH = window_ctrl_pkg::DEF_Y_BITWIDTH,
  parameter int unsigned SCREEN_W   = window_ctrl_pkg::DEF_SCREEN_W,
  parameter int unsigned SCREEN_H   = window_ctrl_pkg::DEF_SCREEN_H,
  parameter int unsigned BUFFER_W   = window_ctrl_pkg::DEF_BUFFER_W,
  parameter int unsigned BUFFER_H   = window_ctrl_pkg::DEF_BUFFER_H
) (
  input  logic                  pixel_valid_i,
  input  logic [X_BITWIDTH-1:0] x_i,
  input  logic [Y_BITWIDTH-1:0] y_i,
  input  logic [X_BITWIDTH-1:0] win_x_i,
  input  logic [Y_BITWIDTH-1:0] win_y_i,
  output logic                  in_win_o,
  output logic                  last_col_o,
  output logic                  last_row_o,
  output logic                  oob_o
);
  // One extra bit so the window end never wraps.
  localparam int unsigned XW = X_BITWIDTH + 1;
  localparam int unsigned YW = Y_BITWIDTH + 1;
  localparam logic [XW-1:0] BUF_W = XW'(BUFFER_W);
  localparam logic [YW-1:0] BUF_H = YW'(BUFFER_H);
  localparam logic [XW-1:0] SCR_W = XW'(SCREEN_W);
  localparam logic [YW-1:0] SCR_H = YW'(SCREEN_H);

  logic [XW-1:0] x_w, x_lo, x_hi;
  logic [YW-1:0] y_w, y_lo, y_hi;

  assign x_w  = {1'b0, x_i};
  assign y_w  = {1'b0, y_i};
  assign x_lo = {1'b0, win_x_i};
  assign y_lo = {1'b0, win_y_i};
  assign x_hi = x_lo + BUF_W;
  assign y_hi = y_lo + BUF_H;

  assign oob_o      = (x_hi > SCR_W) || (y_hi > SCR_H);
  assign in_win_o   = pixel_valid_i
                   && (x_w >= x_lo) && (x_w < x_hi) && (x_w < SCR_W)
                   && (y_w >= y_lo) && (y_w < y_hi) && (y_w < SCR_H);
  assign last_col_o = (x_w == x_hi - XW'(1));
  assign last_row_o = (y_w == y_hi - YW'(1));
endmodule

// File: rtl/window_ctrl_param.sv
// Window controller: fills the BUFFER_W x BUFFER_H window buffer from the camera
// stream and hands it to the mult_adder tree with a ready/ack handshake.
module window_ctrl_param
  import window_ctrl_pkg::*;
#(
  parameter int unsigned X_BITWIDTH     = DEF_X_BITWIDTH,
  parameter int unsigned Y_BITWIDTH     = DEF_Y_BITWIDTH,
  parameter int unsigned PIXEL_BITWIDTH = DEF_PIXEL_BITWIDTH,
  parameter int unsigned SCREEN_W       = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H       = DEF_SCREEN_H,
  parameter int unsigned BUFFER_W       = DEF_BUFFER_W,
  parameter int unsigned BUFFER_H       = DEF_BUFFER_H
) (
  input logic                clock,
  input logic                reset,
  window_ctrl_param_if.slave bus
);
  localparam int unsigned ROWS_W = rows_w(BUFFER_H);

  state_e                    state_q;
  logic [X_BITWIDTH-1:0]     act_x_q;
  logic [Y_BITWIDTH-1:0]     act_y_q;
  logic [PIXEL_BITWIDTH-1:0] pixel_out_q;
  logic                      shift_left_q, shift_up_q, buffer_rdy_q, overrun_q, pos_err_q;
  logic [ROWS_W-1:0]         rows_q, rows_d;

  logic                      frame_start, fill_active;
  logic                      in_win, last_col, last_row, oob;
  logic [X_BITWIDTH-1:0]     win_x;
  logic [Y_BITWIDTH-1:0]     win_y;

  assign frame_start = bus.pixel_valid && (bus.screen_x == '0) && (bus.screen_y == '0);

  // The frame-start pixel already belongs to the new frame, so it is judged
  // against the incoming position rather than the one being replaced.
  assign win_x       = frame_start ? bus.buffer_x_pos : act_x_q;
  assign win_y       = frame_start ? bus.buffer_y_pos : act_y_q;
  assign fill_active = frame_start ? !oob : (state_q == FILL);
  assign rows_d      = (frame_start ? '0 : rows_q) + ROWS_W'(1);

  window_bounds_cmp #(
    .X_BITWIDTH (X_BITWIDTH),
    .Y_BITWIDTH (Y_BITWIDTH),
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H),
    .BUFFER_W   (BUFFER_W),
    .BUFFER_H   (BUFFER_H)
  ) u_bounds (
    .pixel_valid_i (bus.pixel_valid),
    .x_i           (bus.screen_x),
    .y_i           (bus.screen_y),
    .win_x_i       (win_x),
    .win_y_i       (win_y),
    .in_win_o      (in_win),
    .last_col_o    (last_col),
    .last_row_o    (last_row),
    .oob_o         (oob)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      act_x_q      <= '0;
      act_y_q      <= '0;
      pixel_out_q  <= '0;
      shift_left_q <= 1'b0;
      shift_up_q   <= 1'b0;
      buffer_rdy_q <= 1'b0;
      overrun_q    <= 1'b0;
      pos_err_q    <= 1'b0;
      rows_q       <= '0;
    end else begin
      // NOTE: these non-blocking defaults are overridden by later writes in this block; the last write wins.
      shift_left_q <= 1'b0;
      shift_up_q   <= 1'b0;
      overrun_q    <= 1'b0;

      if (frame_start) begin
        act_x_q   <= bus.buffer_x_pos;
        act_y_q   <= bus.buffer_y_pos;
        pos_err_q <= oob;
        rows_q    <= '0;
      end

      unique case (state_q)
        IDLE:  if (frame_start && !oob) state_q <= FILL;
        FILL:  if (frame_start && oob)  state_q <= IDLE;
        READY: begin
          // An ack in the same cycle as a frame start takes precedence over overrun.
          buffer_rdy_q <= !(bus.rdy_ack || frame_start);
          overrun_q    <= frame_start && !bus.rdy_ack;
          if (frame_start)      state_q <= oob ? IDLE : FILL;
          else if (bus.rdy_ack) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (fill_active && in_win) begin
        shift_left_q <= 1'b1;
        pixel_out_q  <= bus.pixel_in;
        if (last_col) begin
          rows_q <= rows_d;
          if (last_row) state_q    <= READY;
          else          shift_up_q <= 1'b1;
        end
      end
    end
  end

  assign bus.pixel_out   = pixel_out_q;
  assign bus.shift_left  = shift_left_q;
  assign bus.shift_up    = shift_up_q;
  assign bus.buffer_rdy  = buffer_rdy_q;
  assign bus.overrun     = overrun_q;
  assign bus.pos_err     = pos_err_q;
  assign bus.rows_filled = rows_q;
endmodule

// File: tb/tb_window_ctrl_param.sv
// Directed bench for window_ctrl_param on a 64x48 raster with a 4x4 window.
module tb_window_ctrl_param;
  import window_ctrl_pkg::*;

  localparam int XB = 10, YB = 10, PB = 8;
  localparam int SW = 64, SH = 48, BW = 4, BH = 4;
  localparam int NPIX = SW * SH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failed = 0;

  window_ctrl_param_if #(
    .X_BITWIDTH(XB), .Y_BITWIDTH(YB), .PIXEL_BITWIDTH(PB), .BUFFER_H(BH)
  ) bus ();

  window_ctrl_param #(
    .X_BITWIDTH(XB), .Y_BITWIDTH(YB), .PIXEL_BITWIDTH(PB),
    .SCREEN_W(SW), .SCREEN_H(SH), .BUFFER_W(BW), .BUFFER_H(BH)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one full raster frame (plus three idle cycles) and checks it.
  task automatic run_frame(
    input string tag, input int px, input int py, input int mid_x, input bit ack_fs,
    input int rst_idx, input bit exp_fill, input bit exp_ovr, input bit exp_perr,
    input int exp_sl, input int exp_su, input int exp_rows, input int exp_rdy);
    int   n_sl = 0, n_su = 0, bad = 0, ovr_cnt = 0, ovr_at = -1, rdy_first = -1;
    int   p, sx, sy;
    logic rdy_prev = 1'b0;
    logic perr_s1 = 1'b0;
    logic e_sl, e_su;
    for (int k = 0; k <= NPIX + 2; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        p = k - 1;
        sx = p % SW;
        sy = p / SW;
        e_sl = 1'b0;
        e_su = 1'b0;
        if (p < NPIX && exp_fill && (rst_idx < 0 || p < rst_idx)) begin
          e_sl = (sx >= px) && (sx < px + BW) && (sy >= py) && (sy < py + BH);
          e_su = e_sl && (sx == px + BW - 1) && (sy != py + BH - 1);
        end
        if (bus.shift_left !== e_sl) bad++;
        if (e_sl && bus.pixel_out !== 8'(sx + sy)) bad++;
        if (bus.shift_up !== e_su) bad++;
        if (bus.shift_left === 1'b1) n_sl++;
        if (bus.shift_up === 1'b1) n_su++;
        if (bus.overrun === 1'b1) begin
          ovr_cnt++;
          if (ovr_at < 0) ovr_at = k;
        end
        if (bus.buffer_rdy === 1'b1 && rdy_prev !== 1'b1 && rdy_first < 0) rdy_first = k;
        if (k == 1) perr_s1 = bus.pos_err;
      end
      rdy_prev = bus.buffer_rdy;
      if (rst_idx >= 0 && k == rst_idx + 1) rst = 1'b0;

      if (k < NPIX) begin
        bus.pixel_valid = 1'b1;
        bus.screen_x    = XB'(k % SW);
        bus.screen_y    = YB'(k / SW);
        bus.pixel_in    = 8'((k % SW) + (k / SW));
      end else begin
        bus.pixel_valid = 1'b0;
      end
      if (k == 0) begin
        bus.buffer_x_pos = XB'(px);
        bus.buffer_y_pos = YB'(py);
        bus.rdy_ack      = ack_fs;
      end else begin
        bus.rdy_ack = 1'b0;
      end
      if (k == 1000 && mid_x >= 0) bus.buffer_x_pos = XB'(mid_x);
      if (k == rst_idx) begin
        rst = 1'b1;
        #1;
        check({tag, "_outs_after_reset"},
              32'({bus.pixel_out, bus.shift_left, bus.shift_up, bus.buffer_rdy,
                   bus.overrun, bus.pos_err, bus.rows_filled}), 32'd0);
      end
    end
    check({tag, "_shift_left_count"}, n_sl, exp_sl);
    check({tag, "_shift_up_count"}, n_su, exp_su);
    check({tag, "_per_pixel_errors"}, bad, 0);
    check({tag, "_buffer_rdy_rise"}, rdy_first, exp_rdy);
    check({tag, "_overrun_count"}, ovr_cnt, exp_ovr ? 1 : 0);
    check({tag, "_overrun_at"}, ovr_at, exp_ovr ? 1 : -1);
    check({tag, "_pos_err"}, 32'(perr_s1), 32'(exp_perr));
    check({tag, "_rows_filled"}, 32'(bus.rows_filled), exp_rows);
  endtask

  // Holds the ack back for a while, then acknowledges the window.
  task automatic hold_ack(input string tag, input int cycles);
    int bad = 0;
    bus.pixel_valid = 1'b0;
    bus.rdy_ack     = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.buffer_rdy !== 1'b1 || bus.shift_left !== 1'b0 || bus.shift_up !== 1'b0) bad++;
    end
    check({tag, "_hold_errors"}, bad, 0);
    bus.rdy_ack = 1'b1;
    @(negedge clk);
    check({tag, "_rdy_after_ack"}, 32'(bus.buffer_rdy), 32'd0);
    check({tag, "_state_after_ack"}, 32'(dut.state_q), 32'(IDLE));
    bus.rdy_ack = 1'b0;
  endtask

  initial begin
    bus.buffer_x_pos = '0;
    bus.buffer_y_pos = '0;
    bus.pixel_valid  = 1'b0;
    bus.screen_x     = '0;
    bus.screen_y     = '0;
    bus.pixel_in     = '0;
    bus.rdy_ack      = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_pixel_out", 32'(bus.pixel_out), 32'd0);
    check("reset_shift_left", 32'(bus.shift_left), 32'd0);
    check("reset_shift_up", 32'(bus.shift_up), 32'd0);
    check("reset_buffer_rdy", 32'(bus.buffer_rdy), 32'd0);
    check("reset_overrun", 32'(bus.overrun), 32'd0);
    check("reset_pos_err", 32'(bus.pos_err), 32'd0);
    check("reset_rows_filled", 32'(bus.rows_filled), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;

    // Last window pixel (13,8) is raster index 525; buffer_rdy visible at sample 527.
    run_frame("basic", 10, 5, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 16, 3, 4, 527);
    hold_ack("basic", 100);

    // Position change mid-frame only affects the next frame.
    run_frame("latch", 10, 5, 20, 1'b0, -1, 1'b1, 1'b0, 1'b0, 16, 3, 4, 527);

    // Left un-acked: the next frame start is an overrun; (23,8) is index 535.
    run_frame("overrun", 20, 5, -1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 16, 3, 4, 537);

    // Ack coincident with frame start: ack wins, no overrun.
    run_frame("ack_at_fs", 20, 5, -1, 1'b1, -1, 1'b1, 1'b0, 1'b0, 16, 3, 4, 537);
    hold_ack("ack_at_fs", 5);

    // 61+4 > 64: rejected window.
    run_frame("pos_err", 61, 5, -1, 1'b0, -1, 1'b0, 1'b0, 1'b1, 0, 0, 0, -1);

    // Bottom-right corner window, exactly fits; last pixel is index 3071.
    run_frame("corner", 60, 44, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 16, 3, 4, 3073);
    hold_ack("corner", 5);

    // Reset on pixel (12,6) = index 396: six shifts, one shift_up, then nothing.
    run_frame("mid_reset", 10, 5, -1, 1'b0, 396, 1'b1, 1'b0, 1'b0, 6, 1, 0, -1);

    run_frame("after_reset", 10, 5, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 16, 3, 4, 527);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/window_ctrl_param.md
Name: window_ctrl_param

Overview:
- Parametrised next-generation window controller for the pixel-stream front end.
- Watches the camera stream (screen_x/screen_y/pixel_in with a valid qualifier) and drives shift_left/shift_up into the BUFFER_W x BUFFER_H window buffer.
- Raises buffer_rdy to the mult_adder tree when the window is full and holds it until the tree acknowledges.
- Adds three things to the original: window position latched per frame, a bounds check, and overrun detection.

Parameters:
- X_BITWIDTH, 10, width of x coordinates.
- Y_BITWIDTH, 10, width of y coordinates.
- PIXEL_BITWIDTH, 8, camera pixel width.
- SCREEN_W, 640, active pixels per line.
- SCREEN_H, 480, active lines per frame.
- BUFFER_W, 16, window width in pixels (>=1).
- BUFFER_H, 16, window height in lines (>=1).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- buffer_x_pos  in  X_BITWIDTH  requested window left column.
- buffer_y_pos  in  Y_BITWIDTH  requested window top line.
- pixel_valid  in  1  screen_x/screen_y/pixel_in valid this cycle.
- screen_x  in  X_BITWIDTH  x of current pixel.
- screen_y  in  Y_BITWIDTH  y of current pixel.
- pixel_in  in  PIXEL_BITWIDTH  current pixel.
- pixel_out  out  PIXEL_BITWIDTH  registered pixel, aligned with shift_left.
- shift_left  out  1  shift pixel_out into current window row.
- shift_up  out  1  window row complete; advance rows.
- buffer_rdy  out  1  window full, data valid for the tree.
- rdy_ack  in  1  tree has consumed the window.
- overrun  out  1  one-cycle pulse: frame restarted before rdy_ack.
- pos_err  out  1  latched position cannot fit the screen.
- rows_filled  out  clog2(BUFFER_H+1)  completed window rows this frame.

Behaviour:
- Reset: all outputs 0, active position registers 0, FSM to IDLE. Reset mid-frame abandons the window; no buffer_rdy until the next frame start.
- Frame start (FS) = pixel_valid && screen_x==0 && screen_y==0.
- On FS, buffer_x_pos/buffer_y_pos are latched into act_x/act_y. Inputs are ignored at all other times.
- All window compares use widths X_BITWIDTH+1 / Y_BITWIDTH+1, so act_x+BUFFER_W cannot wrap.
- pos_err is set at FS if act_x+BUFFER_W > SCREEN_W or act_y+BUFFER_H > SCREEN_H. It is otherwise cleared at FS.
- In-window pixel = pixel_valid && act_x<=x<act_x+BUFFER_W && act_y<=y<act_y+BUFFER_H.
- FSM states:
  - IDLE: wait for FS. FS && !pos_err -> FILL. FS && pos_err -> stay IDLE.
  - FILL: each in-window pixel gives shift_left=1 and pixel_out=pixel_in on the next cycle (latency 1).
    - A pixel with x==act_x+BUFFER_W-1 also gives shift_up=1 in that same output cycle, except on line act_y+BUFFER_H-1. It also increments rows_filled.
    - The last window pixel (x==act_x+BUFFER_W-1, y==act_y+BUFFER_H-1) -> READY. rows_filled reaches BUFFER_H.
    - buffer_rdy rises one cycle after the last shift_left (latency 2 from that input pixel).
  - READY: buffer_rdy held at 1, shift outputs 0.
    - rdy_ack=1 -> buffer_rdy=0 next cycle; go to IDLE.
    - FS before ack: overrun=1 for one cycle, buffer_rdy=0, rows_filled=0, latch new position, go to FILL (or IDLE if pos_err).
    - FS and rdy_ack in the same cycle: the ack wins, no overrun, and the FS is still honoured (-> FILL).
- FS while in FILL: restart silently. rows_filled=0, new position latched, no overrun.
- rdy_ack outside READY is ignored.
- pixel_valid=0 cycles: no state change; shift outputs 0 on the next cycle.
- BUFFER_H==1: shift_up never asserts.
- The window must fall entirely in the active frame. Pixels outside SCREEN_W/SCREEN_H are never in-window.

Decomposition:
- Package window_ctrl_pkg holds:
  - FSM state typedef (IDLE, FILL, READY).
  - Default parameter constants.
  - A rows-counter width function (clog2).
- One natural sub-module, window_bounds_cmp: combinational in-window / last-column / last-pixel / out-of-bounds flags from coordinates plus act_x/act_y.

Test Plan (bench: SCREEN_W=64, SCREEN_H=48, BUFFER_W=BUFFER_H=4, raster scan with pixel_valid=1, pixel_in = x+y):
- Basic fill, pos (10,5) -> 16 shift_left pulses at x 10..13 of lines 5..8; shift_up on x=13 of lines 5,6,7 only; buffer_rdy=1 two cycles after pixel (13,8); rows_filled=4.
- Hold/ack: rdy_ack withheld 100 cycles -> buffer_rdy stays 1, no shifts; ack asserted -> buffer_rdy 0 next cycle, state IDLE.
- Overrun: never ack, second frame starts -> overrun one-cycle pulse at FS+1, buffer_rdy 0, second window fills normally.
- Position latch: change buffer_x_pos to 20 mid-frame -> current frame still uses x 10..13; next frame uses 20..23.
- Bounds: pos (61,5) -> pos_err=1 at FS+1, no shift_left/buffer_rdy all frame; pos (60,44) -> pos_err=0 and full window completes.
- Reset mid-FILL at pixel (12,6) -> all outputs 0 immediately; nothing until next FS; then a clean fill.
